// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and data_memory.
//
// Handshake: a requester raises req with we/addr/wdata and holds all four
// stable until it sees gnt=1 in the same cycle; the transaction is complete
// in that gnt cycle (no separate ready). Read data comes back exactly one
// cycle after the read gnt, qualified by rvalid; rdata is a straight copy of
// mem_rdata and means nothing without rvalid. m1_lock held on a granted m1
// access keeps m1 as sole owner until the first edge where m1_lock is low.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_lock;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Environment side: the two requesters plus the memory.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data memory port between the CPU
// load/store path (m0) and the DMA/debug loader (m1). One access per cycle,
// zero-cycle grant, one-cycle read return routed to the owning requester.
// m1 can lock the port for atomic sequences.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus,
  output logic           state_dbg
);

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e state;
  logic   last;      // port granted most recently (0 or 1)
  logic   rd_pend;   // a read was granted last cycle
  logic   rd_owner;  // which port that read belongs to
  logic   g0;
  logic   g1;

  assign state_dbg = state;

  // Grant decision: combinational from requests, state and last winner.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (state == LOCKED) begin
        g1 = bus.m1_req;
      end else if (bus.m0_req && bus.m1_req) begin
        // Tie: whoever was not served last wins.
        if (last) g0 = 1'b1;
        else      g1 = 1'b1;
      end else begin
        g0 = bus.m0_req;
        g1 = bus.m1_req;
      end
    end
  end

  // Output drive: grants, memory mux and read return.
  always_comb begin
    bus.m0_gnt    = g0;
    bus.m1_gnt    = g1;
    bus.mem_en    = g0 | g1;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    if (g0) begin
      bus.mem_we    = bus.m0_we;
      bus.mem_addr  = bus.m0_addr;
      bus.mem_wdata = bus.m0_wdata;
    end else if (g1) begin
      bus.mem_we    = bus.m1_we;
      bus.mem_addr  = bus.m1_addr;
      bus.mem_wdata = bus.m1_wdata;
    end
    // rd_pend/rd_owner are cleared asynchronously, so rvalid drops with rst.
    bus.m0_rvalid = rd_pend & ~rd_owner;
    bus.m1_rvalid = rd_pend &  rd_owner;
    bus.m0_rdata  = rst ? {DATA_W{1'b0}} : bus.mem_rdata;
    bus.m1_rdata  = rst ? {DATA_W{1'b0}} : bus.mem_rdata;
  end

  // Arbitration state, round-robin pointer and read-return tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB;
      last     <= 1'b1;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      if (g0 || g1) last <= g1;
      rd_pend <= (g0 && !bus.m0_we) || (g1 && !bus.m1_we);
      if ((g0 && !bus.m0_we) || (g1 && !bus.m1_we)) rd_owner <= g1;
      case (state)
        ARB:     if (g1 && bus.m1_lock) state <= LOCKED;
        LOCKED:  if (!bus.m1_lock)      state <= ARB;
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a small word memory model behind the
// arbiter, a reference memory plus per-port expected-read queues, and a
// read-return monitor that checks data and exact one-cycle latency.
module tb_dmem_arbiter;

  logic       clk;
  logic       rst;
  logic [0:0] state_dbg;
  int         checks;
  int         failures;
  logic [31:0] cyc;
  logic [63:0] exp0_q[$];
  logic [63:0] exp1_q[$];
  logic [31:0] ref_mem [0:63];
  logic [31:0] mem [0:63];
  logic [63:0] e0;
  logic [63:0] e1;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Memory model: writes at the edge, read data registered one cycle later.
  always @(posedge clk) begin
    if (rst) begin
      mem[6'h04]    <= 32'hDEADBEEF;
      mem[6'h01]    <= 32'h00000011;
      mem[6'h02]    <= 32'h00000022;
      bus.mem_rdata <= 32'h0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[7:2]];
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read-return scoreboard: every rvalid must match the front of its queue
  // and arrive exactly one cycle after the grant.
  always @(posedge clk) begin
    #1;
    if (bus.m0_rvalid) begin
      if (exp0_q.size() == 0) check("m0_rvalid_unexpected", 1, 0);
      else begin
        e0 = exp0_q.pop_front();
        check("m0_rd_cycle", cyc, e0[63:32]);
        check("m0_rdata", bus.m0_rdata, e0[31:0]);
      end
    end else if (exp0_q.size() != 0 && exp0_q[0][63:32] <= cyc) begin
      e0 = exp0_q.pop_front();
      check("m0_rvalid_missing", 0, 1);
    end
    if (bus.m1_rvalid) begin
      if (exp1_q.size() == 0) check("m1_rvalid_unexpected", 1, 0);
      else begin
        e1 = exp1_q.pop_front();
        check("m1_rd_cycle", cyc, e1[63:32]);
        check("m1_rdata", bus.m1_rdata, e1[31:0]);
      end
    end else if (exp1_q.size() != 0 && exp1_q[0][63:32] <= cyc) begin
      e1 = exp1_q.pop_front();
      check("m1_rvalid_missing", 0, 1);
    end
  end

  // One cycle of stimulus with the expected grants; checks grants and the
  // memory-side drive, then updates the reference model from the expected
  // winner.
  task automatic drive(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                       input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                       input bit lk, input bit g0, input bit g1, input string tag);
    logic        x_we;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    @(negedge clk);
    bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
    bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
    bus.m1_lock = lk;
    #1;
    check($sformatf("%s_gnt", tag), {bus.m1_gnt, bus.m0_gnt}, {g1, g0});
    x_we = 1'b0; x_addr = 32'h0; x_wdata = 32'h0;
    if (g0) begin x_we = w0; x_addr = a0; x_wdata = d0; end
    else if (g1) begin x_we = w1; x_addr = a1; x_wdata = d1; end
    check($sformatf("%s_mem", tag),
          {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
          {g0 | g1, x_we, x_addr, x_wdata});
    if (g0) begin
      if (w0) ref_mem[a0[7:2]] = d0;
      else    exp0_q.push_back({cyc + 32'd1, ref_mem[a0[7:2]]});
    end
    if (g1) begin
      if (w1) ref_mem[a1[7:2]] = d1;
      else    exp1_q.push_back({cyc + 32'd1, ref_mem[a1[7:2]]});
    end
  endtask

  task automatic idle(input bit lk);
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, lk, 0, 0, "idle");
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 32'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    ref_mem[6'h04] = 32'hDEADBEEF;
    ref_mem[6'h01] = 32'h00000011;
    ref_mem[6'h02] = 32'h00000022;
    rst = 1'b1;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
    bus.m1_lock = 0;

    // Reset: outputs quiet even with both ports requesting.
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.m0_req = 1; bus.m1_req = 1; bus.m0_addr = 32'h4;
    #1;
    check("rst_gnt", {bus.m1_gnt, bus.m0_gnt}, 2'b00);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 2'b00);
    check("rst_state", state_dbg, 0);
    @(negedge clk);
    bus.m0_req = 0; bus.m1_req = 0;
    rst = 1'b0;

    // First tie after reset goes to m0, then m1 is served.
    drive(1, 0, 32'h4, 0, 1, 0, 32'h8, 0, 0, 1, 0, "tie0");
    drive(0, 0, 32'h0, 0, 1, 0, 32'h8, 0, 0, 0, 1, "tie1");

    // Contention fairness: six writes, grants 0,1,0,1,0,1.
    drive(1, 1, 32'h40, 32'hA0, 1, 1, 32'h60, 32'hB0, 0, 1, 0, "fair1");
    drive(1, 1, 32'h44, 32'hA1, 1, 1, 32'h60, 32'hB0, 0, 0, 1, "fair2");
    drive(1, 1, 32'h44, 32'hA1, 1, 1, 32'h64, 32'hB1, 0, 1, 0, "fair3");
    drive(1, 1, 32'h48, 32'hA2, 1, 1, 32'h64, 32'hB1, 0, 0, 1, "fair4");
    drive(1, 1, 32'h48, 32'hA2, 1, 1, 32'h68, 32'hB2, 0, 1, 0, "fair5");
    drive(0, 0, 32'h0,  32'h0,  1, 1, 32'h68, 32'hB2, 0, 0, 1, "fair6");

    // Read back the written words, back-to-back alternating owners.
    drive(1, 0, 32'h40, 0, 1, 0, 32'h60, 0, 0, 1, 0, "rb1");
    drive(1, 0, 32'h44, 0, 1, 0, 32'h60, 0, 0, 0, 1, "rb2");
    drive(1, 0, 32'h44, 0, 1, 0, 32'h64, 0, 0, 1, 0, "rb3");
    drive(1, 0, 32'h48, 0, 1, 0, 32'h64, 0, 0, 0, 1, "rb4");
    drive(1, 0, 32'h48, 0, 1, 0, 32'h68, 0, 0, 1, 0, "rb5");
    drive(0, 0, 32'h0,  0, 1, 0, 32'h68, 0, 0, 0, 1, "rb6");
    idle(0);

    // Single requester read of 0xDEADBEEF.
    drive(1, 0, 32'h10, 0, 0, 0, 32'h0, 0, 0, 1, 0, "single");
    idle(0);

    // Read ownership: alternating single-port reads.
    drive(1, 0, 32'h4, 0, 0, 0, 32'h0, 0, 0, 1, 0, "own1");
    drive(0, 0, 32'h0, 0, 1, 0, 32'h8, 0, 0, 0, 1, "own2");
    drive(1, 0, 32'h4, 0, 0, 0, 32'h0, 0, 0, 1, 0, "own3");
    drive(0, 0, 32'h0, 0, 1, 0, 32'h8, 0, 0, 0, 1, "own4");
    idle(0);

    // Write then read the same address in consecutive cycles.
    drive(0, 0, 32'h0,  0, 1, 1, 32'h20, 32'hCAFEF00D, 0, 0, 1, "wtr_w");
    drive(1, 0, 32'h20, 0, 0, 0, 32'h0,  0,            0, 1, 0, "wtr_r");
    idle(0);

    // Lock with m1 idle has no effect in ARB.
    drive(1, 0, 32'h8, 0, 0, 0, 32'h0, 0, 1, 1, 0, "lk_noreq");
    idle(0);
    check("lk_noreq_state", state_dbg, 0);

    // Lock: m1 wins the tie with lock set, then idles holding the lock.
    drive(1, 0, 32'h4, 0, 1, 1, 32'h30, 32'h5A5A, 1, 0, 1, "lock_gnt");
    drive(1, 0, 32'h4, 0, 0, 0, 32'h0, 0, 1, 0, 0, "lock_hold1");
    check("lock_state", state_dbg, 1);
    drive(1, 0, 32'h4, 0, 0, 0, 32'h0, 0, 1, 0, 0, "lock_hold2");
    drive(1, 0, 32'h4, 0, 0, 0, 32'h0, 0, 1, 0, 0, "lock_hold3");
    drive(1, 0, 32'h4, 0, 0, 0, 32'h0, 0, 0, 0, 0, "lock_drop");
    drive(1, 0, 32'h4, 0, 0, 0, 32'h0, 0, 0, 1, 0, "lock_after");
    idle(0);

    // Unlocking access is still granted while m0 waits.
    drive(0, 0, 32'h0,  0, 1, 1, 32'h34, 32'h77, 1, 0, 1, "unl_lock");
    drive(1, 0, 32'h30, 0, 1, 0, 32'h34, 0,      0, 0, 1, "unl_acc");
    drive(1, 0, 32'h30, 0, 0, 0, 32'h0,  0,      0, 1, 0, "unl_m0");
    idle(0);

    // Reset mid-operation while LOCKED with an m1 read pending.
    drive(0, 0, 32'h0, 0, 1, 1, 32'h38, 32'h99, 1, 0, 1, "rmid_lock");
    drive(1, 0, 32'h4, 0, 1, 0, 32'h34, 0,      1, 0, 1, "rmid_rd");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rmid_state", state_dbg, 0);
    check("rmid_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 2'b00);
    check("rmid_gnt", {bus.m1_gnt, bus.m0_gnt}, 2'b00);
    check("rmid_mem_en", bus.mem_en, 0);
    @(negedge clk);
    bus.m0_req = 0; bus.m1_req = 0; bus.m1_lock = 0;
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 32'h10, 0, 1, 0, 32'h8, 0, 0, 1, 0, "rmid_tie");
    idle(0);
    idle(0);

    check("exp0_drained", exp0_q.size(), 0);
    check("exp1_drained", exp1_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single data memory port between the CPU load/store path (port 0) and a DMA/debug loader (port 1). It sits between the core's ALU-result/`regdata2` load-store path and `data_memory`. It accepts at most one transaction per cycle and grants round-robin. Port 1 may lock the memory for an atomic sequence, and read data returns to the owning requester with a fixed one-cycle latency.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `m0_req`  in  1  CPU requests a memory access this cycle.
- `m0_we`  in  1  1 = write, 0 = read.
- `m0_addr`  in  ADDR_W  CPU byte address.
- `m0_wdata`  in  DATA_W  CPU write data.
- `m0_gnt`  out  1  CPU transaction accepted this cycle (combinational).
- `m0_rvalid`  out  1  CPU read data valid (registered).
- `m0_rdata`  out  DATA_W  CPU read data.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: same meanings, for port 1.
- `m1_lock`  in  1  when set on a granted m1 transaction, m1 keeps exclusive ownership.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after a read strobe.

## Operation
- **Requester rule.** A requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`=1. The transaction completes in the `gnt` cycle.
- **State machine:** ARB, LOCKED.
  - ARB with one requester: that requester is granted.
  - ARB with both requesting: the port not served last wins. The last-winner pointer `last` updates on every grant.
  - ARB → LOCKED when m1 is granted with `m1_lock`=1.
  - LOCKED: only m1 may be granted, and `m0_gnt`=0 even if m0 is requesting.
  - LOCKED → ARB at the first clock edge where `m1_lock`=0. That cycle may still carry an m1 grant (the unlocking access).
- **Memory drive.**
  - `mem_en` = `m0_gnt` | `m1_gnt`.
  - `mem_we`, `mem_addr` and `mem_wdata` are muxed from the winner.
  - When there is no grant, `mem_we`=0 and addr/wdata = 0.
- **Read return.**
  - A read grant sets the 1-bit `rd_pend` and the `rd_owner` register.
  - Next cycle, `mX_rvalid`=1 for the owner only.
  - `m0_rdata` and `m1_rdata` both equal `mem_rdata` combinationally. Requesters qualify it with their `rvalid`.
- **Writes** produce no `rvalid`.
- **Fairness:** with both requesting continuously in ARB, grants alternate 0,1,0,1. No port waits more than 1 cycle outside LOCKED.
- **Lock outside its normal use.** `m1_lock` with `m1_req`=0 while in ARB has no effect. In LOCKED, m1 may idle (`req`=0) while still holding lock.

## Timing
- **Reset values:** state = ARB, `last` = 1 (m0 wins the first tie), `rd_pend` = 0, `rd_owner` = 0. All `gnt`/`rvalid`/`mem_*` outputs are 0 while `rst`=1.
- **Grant latency:** 0 cycles, combinational from `req` and state.
- **Read latency:** `rvalid` is asserted exactly 1 cycle after the read `gnt`.
- **Throughput:** back-to-back reads give one `rvalid` per cycle, with the owner tracked per cycle.
- **Write then read** to the same address in consecutive cycles returns the new data, since the memory writes at the edge.
- **Reset mid-operation:** a pending `rvalid` is dropped and LOCKED is exited immediately.
- **Simultaneous events:**
  - In LOCKED with `m1_lock` falling and m0 requesting, m0 can win only in the following cycle.
  - A tie in the cycle after an m0 grant goes to m1.

## Test plan
- **Reset.** Assert `rst` asynchronously mid-cycle while a read is pending → all outputs 0 immediately. After release, state ARB, and the first tie is granted to m0.
- **Single requester read.** m0 reads addr 0x10, where memory holds 0xDEADBEEF → `m0_gnt`=1 and `mem_en`=1 with `mem_we`=0 in cycle N. In cycle N+1, `m0_rvalid`=1 and `m0_rdata`=0xDEADBEEF; `m1_rvalid`=0 throughout.
- **Contention fairness.** Both ports issue 6 continuous writes to distinct addresses → grant order 0,1,0,1,0,1, and memory contents match each port's data afterwards.
- **Lock.** m1 is granted with `m1_lock`=1, then m1 idles 3 cycles with lock held while m0 requests → `m0_gnt`=0 for those cycles. When lock drops, m0 is granted in the next cycle.
- **Read ownership.** Alternating reads m0@0x4 (holds 0x11) and m1@0x8 (holds 0x22) back-to-back → the `rvalid` pulses alternate owners, with m0 seeing 0x11 and m1 seeing 0x22, each 1 cycle after its grant.
- **Write-then-read.** m1 writes 0xCAFEF00D to 0x20 in cycle N, then m0 reads 0x20 in cycle N+1 → `m0_rdata`=0xCAFEF00D with `m0_rvalid` in cycle N+2.
